// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin owner of the seven-segment display with dwell timer and hold
// Ports:
//   clk          rising-edge clock
//   rst_i        synchronous active-high reset
//   req_i[3:0]   level request per source
//   data_i[127:0] source words, source i at [32*i+31:32*i]
//   hold_i       freezes the dwell counter
//   grant_o[3:0] one-hot owner, zero when idle
//   src_o[1:0]   owner index, keeps the last owner while idle
//   busy_o       an owner is granted
//   data_o[31:0] registered owner word for the display driver
module disp_arbiter #(
    parameter int DWELL_CLOCKS = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic [3:0]   req_i,
    input  logic [127:0] data_i,
    input  logic         hold_i,
    output logic [3:0]   grant_o,
    output logic [1:0]   src_o,
    output logic         busy_o,
    output logic [31:0]  data_o
);
    localparam int CW = $clog2(DWELL_CLOCKS);
    typedef enum logic {IDLE, SHOW} state_t;
    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d, last_q, last_d, win;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          ev, go;
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end
    // Scan from farthest to nearest so the first requester after last_q wins;
    // offset 4 wraps to last_q itself, which lets a lone owner keep the display.
    always_comb begin
        win = last_q;
        for (int k = 4; k >= 1; k--)
            if (req_i[last_q + 2'(k)]) win = last_q + 2'(k);
    end
    // In SHOW last_q always equals owner_q, so one search base serves both states.
    always_comb begin
        ev      = !req_i[owner_q] || (cnt_q == CW'(DWELL_CLOCKS - 1) && !hold_i);
        go      = state_q == IDLE || ev;
        state_d = go ? (|req_i ? SHOW : IDLE) : state_q;
        owner_d = go && |req_i ? win : owner_q;
        last_d  = go && |req_i ? win : last_q;
        cnt_d   = go ? '0 : (hold_i ? cnt_q : cnt_q + 1'b1);
        data_d  = state_d == SHOW ? data_i[{owner_d, 5'd0} +: 32] : 32'h0;
    end
    always_comb begin
        busy_o  = state_q == SHOW;
        grant_o = busy_o ? 4'b0001 << owner_q : 4'b0000;
        src_o   = owner_q;
        data_o  = data_q;
    end
endmodule
